// File: rtl/acq_pkg.sv
// ---------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the acquisition window controller:
//   - default widths for the delay counter, record length and pulse counter
//   - state encoding of the controller FSM
// No ports (package).
// ---------------------------------------------------------------------------
package acq_pkg;

    localparam int DEF_DELAY_W = 16;
    localparam int DEF_LEN_W   = 16;
    localparam int DEF_CNT_W   = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_DELAY  = 3'd2;
    localparam logic [2:0] ST_RECORD = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/trig_edge_det.sv
// ---------------------------------------------------------------------------
// trig_edge_det
// Rising-edge detector for the decoded trigger level. The previous level is
// held in a register; the edge is flagged in the cycle the level first goes
// high, so the FSM can react at the end of that same cycle.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   trigger_start in   decoded trigger level
//   trig_edge     out  high for the first cycle of a high level
// ---------------------------------------------------------------------------
module trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic trigger_start,
    output logic trig_edge
);

    logic trig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trigger_start;
        end
    end

    assign trig_edge = trigger_start & ~trig_q;

endmodule

// File: rtl/acq_window_ctrl.sv
// ---------------------------------------------------------------------------
// acq_window_ctrl
// Arms a sequence of pulse_num records, waits for each trigger edge, waits a
// fixed pre-record delay and then strobes record_valid for record_len samples.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   arm, abort                sequence start (IDLE only) / synchronous abort
//   trigger_start             decoded trigger level
//   delay_cfg, record_len,
//   pulse_num                 configuration, latched on arm
//   trigger_ready             high only while waiting for a trigger
//   record_valid, sample_idx  sample window strobe and index
//   first_record, last_record record qualifiers
//   pulse_cnt                 records completed in this sequence
//   busy, acq_done            not-idle flag / sequence-complete pulse
//   trig_missed               trigger edge seen while delaying/recording
// All outputs are registered; they are computed from next-state values.
// ---------------------------------------------------------------------------
module acq_window_ctrl
    import acq_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger_start,
    input  logic [DELAY_W-1:0] delay_cfg,
    input  logic [LEN_W-1:0]   record_len,
    input  logic [CNT_W-1:0]   pulse_num,
    output logic               trigger_ready,
    output logic               record_valid,
    output logic [LEN_W-1:0]   sample_idx,
    output logic               first_record,
    output logic               last_record,
    output logic [CNT_W-1:0]   pulse_cnt,
    output logic               busy,
    output logic               acq_done,
    output logic               trig_missed
);

    logic               trig_edge;

    logic [2:0]         state_q, state_d;
    logic [DELAY_W-1:0] delay_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   num_q;
    logic               cfg_load;

    logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [LEN_W-1:0]   sample_q, sample_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               missed_d;

    logic               trigger_ready_q, record_valid_q, first_q, last_q;
    logic               busy_q, done_q, missed_q;

    trig_edge_det u_edge (
        .clk           (clk),
        .rst           (rst),
        .trigger_start (trigger_start),
        .trig_edge     (trig_edge)
    );

    always_comb begin
        state_d     = state_q;
        cfg_load    = 1'b0;
        delay_cnt_d = delay_cnt_q;
        sample_d    = '0;
        cnt_d       = cnt_q;
        missed_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    cfg_load = 1'b1;
                    cnt_d    = '0;
                    // Zero records or zero-length records: nothing to capture.
                    if (pulse_num == '0 || record_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (trig_edge) begin
                    if (delay_q == '0) begin
                        state_d = ST_RECORD;
                    end else begin
                        state_d     = ST_DELAY;
                        delay_cnt_d = delay_q;
                    end
                end
            end
            ST_DELAY: begin
                missed_d    = trig_edge;
                delay_cnt_d = delay_cnt_q - DELAY_W'(1);
                // Counter holds `delay` on the first DELAY cycle, so leaving
                // at 1 puts the first sample exactly delay cycles after entry.
                if (delay_cnt_q == DELAY_W'(1)) begin
                    state_d = ST_RECORD;
                end
            end
            ST_RECORD: begin
                missed_d = trig_edge;
                if (sample_q == len_q - LEN_W'(1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == num_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else begin
                    sample_d = sample_q + LEN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything above, including an arm in IDLE and the
        // final sample of a record; the completed count is kept.
        if (abort) begin
            state_d  = ST_IDLE;
            cfg_load = 1'b0;
            cnt_d    = cnt_q;
            missed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            delay_q         <= '0;
            len_q           <= '0;
            num_q           <= '0;
            delay_cnt_q     <= '0;
            sample_q        <= '0;
            cnt_q           <= '0;
            trigger_ready_q <= 1'b0;
            record_valid_q  <= 1'b0;
            first_q         <= 1'b0;
            last_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            missed_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            cnt_q       <= cnt_d;
            if (cfg_load) begin
                delay_q <= delay_cfg;
                len_q   <= record_len;
                num_q   <= pulse_num;
            end
            sample_q        <= (state_d == ST_RECORD) ? sample_d : '0;
            trigger_ready_q <= (state_d == ST_ARMED);
            record_valid_q  <= (state_d == ST_RECORD);
            first_q         <= (state_d == ST_RECORD) && (cnt_d == '0);
            last_q          <= (state_d == ST_RECORD) && (cnt_d == num_q - CNT_W'(1));
            busy_q          <= (state_d != ST_IDLE);
            done_q          <= (state_d == ST_DONE);
            missed_q        <= missed_d;
        end
    end

    assign trigger_ready = trigger_ready_q;
    assign record_valid  = record_valid_q;
    assign sample_idx    = sample_q;
    assign first_record  = first_q;
    assign last_record   = last_q;
    assign pulse_cnt     = cnt_q;
    assign busy          = busy_q;
    assign acq_done      = done_q;
    assign trig_missed   = missed_q;

endmodule

// File: tb/tb_acq_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acq_window_ctrl
// Directed scenarios with constant expectations, followed by a randomized run
// checked every cycle against a timeline-based reference model.
// ---------------------------------------------------------------------------
module tb_acq_window_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trigger_start = 1'b0;
    logic [15:0] delay_cfg = '0;
    logic [15:0] record_len = '0;
    logic [15:0] pulse_num = '0;
    logic        trigger_ready, record_valid, first_record, last_record;
    logic        busy, acq_done, trig_missed;
    logic [15:0] sample_idx, pulse_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    acq_window_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .abort         (abort),
        .trigger_start (trigger_start),
        .delay_cfg     (delay_cfg),
        .record_len    (record_len),
        .pulse_num     (pulse_num),
        .trigger_ready (trigger_ready),
        .record_valid  (record_valid),
        .sample_idx    (sample_idx),
        .first_record  (first_record),
        .last_record   (last_record),
        .pulse_cnt     (pulse_cnt),
        .busy          (busy),
        .acq_done      (acq_done),
        .trig_missed   (trig_missed)
    );

    // Reference model: a sequence is a phase plus an absolute-time window
    // [m_ws, m_we] computed when a trigger is accepted.
    localparam int M_IDLE = 0, M_WAIT = 1, M_WIN = 2, M_DONE = 3;
    int cyc = 0;
    int m_mode = M_IDLE;
    int m_ws = 0, m_we = 0, m_cnt = 0, m_d = 0, m_len = 0, m_num = 0;
    bit m_prev = 1'b0, m_missed = 1'b0;

    task automatic model_step();
        bit tedge;
        tedge    = trigger_start & ~m_prev;
        m_prev   = trigger_start;
        m_missed = 1'b0;
        if (!rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_prev = 1'b0;
            m_d = 0; m_len = 0; m_num = 0;
        end else if (abort) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (arm) begin
                    m_d = int'(delay_cfg); m_len = int'(record_len); m_num = int'(pulse_num);
                    m_cnt = 0;
                    m_mode = (m_num == 0 || m_len == 0) ? M_DONE : M_WAIT;
                end
                M_WAIT: if (tedge) begin
                    m_ws = cyc + 1 + m_d;
                    m_we = m_ws + m_len - 1;
                    m_mode = M_WIN;
                end
                M_WIN: begin
                    if (tedge) m_missed = 1'b1;
                    if (cyc == m_we) begin
                        m_cnt++;
                        m_mode = (m_cnt == m_num) ? M_DONE : M_WAIT;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_tests++;
        if ({trigger_ready, record_valid, sample_idx, first_record, last_record,
             pulse_cnt, busy, acq_done, trig_missed} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tr=%b rv=%b idx=%0d busy=%b cnt=%0d done=%b, required all 0",
                     trigger_ready, record_valid, sample_idx, busy, pulse_cnt, acq_done);
        end
        rst = 1'b1;
        trigger_start = 1'b1;
        tick();
        trigger_start = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || trigger_ready !== 1'b0 || trig_missed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_trigger: got busy=%b tr=%b missed=%b, required 0 0 0",
                     busy, trigger_ready, trig_missed);
        end
    endtask

    task automatic test_basic();
        delay_cfg = 16'd3; record_len = 16'd4; pulse_num = 16'd2; arm = 1'b1;
        tick();
        arm = 1'b0;
        // Latched copies must be used from here on.
        delay_cfg = 16'd9; record_len = 16'd9; pulse_num = 16'd9;
        n_tests++;
        if (trigger_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_armed: got tr=%b busy=%b, required 1 1", trigger_ready, busy);
        end
        for (int p = 0; p < 2; p++) begin
            trigger_start = 1'b1;
            tick();
            trigger_start = 1'b0;
            n_tests++;
            if (trigger_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_ready_drop: got tr=%b, required 0", trigger_ready);
            end
            for (int c = 1; c <= 7; c++) begin
                bit e_rv;
                e_rv = (c >= 4);
                n_tests++;
                if (record_valid !== e_rv ||
                    (e_rv && (sample_idx !== 16'(c - 4) || first_record !== (p == 0) ||
                              last_record !== (p == 1)))) begin
                    n_fail++;
                    $display("FAIL basic_window p%0d T+%0d: got rv=%b idx=%0d first=%b last=%b, required rv=%b idx=%0d first=%b last=%b",
                             p, c, record_valid, sample_idx, first_record, last_record,
                             e_rv, c - 4, p == 0, p == 1);
                end
                tick();
            end
            if (p == 0) begin
                n_tests++;
                if (trigger_ready !== 1'b1 || pulse_cnt !== 16'd1 || acq_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_rearm: got tr=%b cnt=%0d done=%b, required 1 1 0",
                             trigger_ready, pulse_cnt, acq_done);
                end
            end else begin
                n_tests++;
                if (acq_done !== 1'b1 || pulse_cnt !== 16'd2 || record_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_done: got done=%b cnt=%0d rv=%b, required 1 2 0",
                             acq_done, pulse_cnt, record_valid);
                end
                tick();
                n_tests++;
                if (acq_done !== 1'b0 || busy !== 1'b0 || pulse_cnt !== 16'd2) begin
                    n_fail++;
                    $display("FAIL basic_idle: got done=%b busy=%b cnt=%0d, required 0 0 2",
                             acq_done, busy, pulse_cnt);
                end
            end
        end
    endtask

    task automatic test_zero_delay();
        delay_cfg = 16'd0; record_len = 16'd1; pulse_num = 16'd1; arm = 1'b1;
        tick();
        arm = 1'b0;
        trigger_start = 1'b1;
        tick();
        trigger_start = 1'b0;
        n_tests++;
        if (trigger_ready !== 1'b0 || record_valid !== 1'b1 || sample_idx !== 16'd0 ||
            first_record !== 1'b1 || last_record !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_delay_T1: got tr=%b rv=%b idx=%0d first=%b last=%b, required 0 1 0 1 1",
                     trigger_ready, record_valid, sample_idx, first_record, last_record);
        end
        tick();
        n_tests++;
        if (record_valid !== 1'b0 || acq_done !== 1'b1 || pulse_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL zero_delay_T2: got rv=%b done=%b cnt=%0d, required 0 1 1",
                     record_valid, acq_done, pulse_cnt);
        end
        tick();
    endtask

    task automatic test_zero_pulses();
        for (int k = 0; k < 2; k++) begin
            int rv_seen, tr_seen;
            rv_seen = 0; tr_seen = 0;
            delay_cfg = 16'd2;
            record_len = (k == 0) ? 16'd3 : 16'd0;
            pulse_num  = (k == 0) ? 16'd0 : 16'd3;
            arm = 1'b1;
            tick();
            arm = 1'b0;
            n_tests++;
            if (acq_done !== 1'b1 || busy !== 1'b1 || pulse_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL zero_cfg%0d_done: got done=%b busy=%b cnt=%0d, required 1 1 0",
                         k, acq_done, busy, pulse_cnt);
            end
            for (int c = 0; c < 4; c++) begin
                rv_seen += int'(record_valid);
                tr_seen += int'(trigger_ready);
                trigger_start = c[0];
                tick();
            end
            trigger_start = 1'b0;
            n_tests++;
            if (rv_seen != 0 || tr_seen != 0 || busy !== 1'b0 || acq_done !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_cfg%0d_quiet: got rv_cycles=%0d tr_cycles=%0d busy=%b done=%b, required 0 0 0 0",
                         k, rv_seen, tr_seen, busy, acq_done);
            end
        end
    endtask

    task automatic test_missed();
        int missed_cnt;
        missed_cnt = 0;
        delay_cfg = 16'd4; record_len = 16'd3; pulse_num = 16'd1; arm = 1'b1;
        tick();
        arm = 1'b0;
        trigger_start = 1'b1;
        tick();
        trigger_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            bit e_rv;
            e_rv = (c >= 5 && c <= 7);
            missed_cnt += int'(trig_missed);
            n_tests++;
            if (record_valid !== e_rv || (e_rv && sample_idx !== 16'(c - 5)) ||
                acq_done !== (c == 8)) begin
                n_fail++;
                $display("FAIL missed_window T+%0d: got rv=%b idx=%0d done=%b, required rv=%b idx=%0d done=%b",
                         c, record_valid, sample_idx, acq_done, e_rv, c - 5, c == 8);
            end
            trigger_start = (c == 2 || c == 5);
            tick();
        end
        trigger_start = 1'b0;
        n_tests++;
        if (missed_cnt != 2) begin
            n_fail++;
            $display("FAIL missed_count: got %0d pulses, required 2", missed_cnt);
        end
    endtask

    task automatic test_held_trigger();
        int rv_cnt;
        rv_cnt = 0;
        delay_cfg = 16'd0; record_len = 16'd2; pulse_num = 16'd2; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int c = 0; c < 10; c++) begin
            trigger_start = (c < 5);
            rv_cnt += int'(record_valid);
            tick();
        end
        trigger_start = 1'b0;
        n_tests++;
        if (rv_cnt != 2 || pulse_cnt !== 16'd1 || trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL held_trigger: got rv_cycles=%0d cnt=%0d tr=%b, required 2 1 1",
                     rv_cnt, pulse_cnt, trigger_ready);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || pulse_cnt !== 16'd1 || acq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL held_abort: got busy=%b cnt=%0d done=%b, required 0 1 0",
                     busy, pulse_cnt, acq_done);
        end
    endtask

    task automatic test_abort_arm();
        int done_cnt, rv_cnt;
        delay_cfg = 16'd1; record_len = 16'd5; pulse_num = 16'd3; arm = 1'b1;
        tick();
        arm = 1'b0;
        trigger_start = 1'b1;
        tick();
        trigger_start = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (record_valid !== 1'b1 || sample_idx !== 16'd2) begin
            n_fail++;
            $display("FAIL abort_pre: got rv=%b idx=%0d, required 1 2", record_valid, sample_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (record_valid !== 1'b0 || busy !== 1'b0 || pulse_cnt !== 16'd0 || trigger_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got rv=%b busy=%b cnt=%0d tr=%b, required 0 0 0 0",
                     record_valid, busy, pulse_cnt, trigger_ready);
        end
        done_cnt = int'(acq_done);
        for (int c = 0; c < 4; c++) begin
            tick();
            done_cnt += int'(acq_done);
        end
        n_tests++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d acq_done cycles, required 0", done_cnt);
        end
        // arm while recording must be ignored
        delay_cfg = 16'd0; record_len = 16'd3; pulse_num = 16'd1; arm = 1'b1;
        tick();
        arm = 1'b0;
        trigger_start = 1'b1;
        tick();
        trigger_start = 1'b0;
        record_len = 16'd7; pulse_num = 16'd5;
        rv_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            rv_cnt   += int'(record_valid);
            done_cnt += int'(acq_done);
            arm = (c == 2);
            tick();
        end
        arm = 1'b0;
        n_tests++;
        if (rv_cnt != 3 || done_cnt != 1 || pulse_cnt !== 16'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_ignored: got rv_cycles=%0d done=%0d cnt=%0d busy=%b, required 3 1 1 0",
                     rv_cnt, done_cnt, pulse_cnt, busy);
        end
    endtask

    task automatic test_async_reset();
        int act;
        delay_cfg = 16'd10; record_len = 16'd2; pulse_num = 16'd1; arm = 1'b1;
        tick();
        arm = 1'b0;
        trigger_start = 1'b1;
        tick();
        trigger_start = 1'b0;
        tick(); tick();
        n_tests++;
        if (busy !== 1'b1 || trigger_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_pre: got busy=%b tr=%b, required 1 0", busy, trigger_ready);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({trigger_ready, record_valid, sample_idx, first_record, last_record,
             pulse_cnt, busy, acq_done, trig_missed} !== 39'd0) begin
            n_fail++;
            $display("FAIL areset_async: got busy=%b tr=%b rv=%b cnt=%0d, required all 0 before next edge",
                     busy, trigger_ready, record_valid, pulse_cnt);
        end
        tick(); tick();
        rst = 1'b1;
        act = 0;
        for (int c = 0; c < 8; c++) begin
            trigger_start = c[0];
            tick();
            act += int'(busy) + int'(trigger_ready) + int'(record_valid) + int'(trig_missed);
        end
        trigger_start = 1'b0;
        n_tests++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL areset_no_arm: got %0d active output cycles, required 0", act);
        end
    endtask

    task automatic test_random();
        logic [38:0] got, expv;
        bit          e_rv;
        logic [15:0] e_idx;
        rst = 1'b0; arm = 1'b0; abort = 1'b0; trigger_start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            arm           = ($urandom_range(7) == 0);
            abort         = ($urandom_range(39) == 0);
            delay_cfg     = 16'($urandom_range(5));
            record_len    = 16'($urandom_range(4));
            pulse_num     = 16'($urandom_range(3));
            if ($urandom_range(2) == 0) trigger_start = ~trigger_start;
            tick();
            e_rv  = (m_mode == M_WIN) && (cyc >= m_ws);
            e_idx = e_rv ? 16'(cyc - m_ws) : 16'd0;
            expv  = {m_mode == M_WAIT, e_rv, e_idx, e_rv && m_cnt == 0,
                     e_rv && m_cnt == m_num - 1, 16'(m_cnt), m_mode != M_IDLE,
                     m_mode == M_DONE, m_missed};
            got   = {trigger_ready, record_valid, sample_idx, first_record, last_record,
                     pulse_cnt, busy, acq_done, trig_missed};
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL random cycle %0d: got {tr,rv,idx,first,last,cnt,busy,done,missed}=%h, required %h",
                         c, got, expv);
            end
        end
        arm = 1'b0; abort = 1'b0; trigger_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_delay();
        test_zero_pulses();
        test_missed();
        test_held_trigger();
        test_abort_arm();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
